tape_burst_reader: RTL and testbench

Parametrised burst-mode successor to the tape-file word fetcher. It streams a tape image out of DDR through the IPIF master-read port in multi-word bursts and buffers it in a local FIFO. It presents a show-ahead 32-bit word stream to the tape-playback logic. The block sits between the AXI/IPIF master bridge and the C64 datasette emulation, and adds burst prefetch, backpressure, and clean restart mid-burst.

---
 rtl/tape_reader_pkg.sv | 18 +
 rtl/tape_sync_fifo.sv | 58 +++++
 rtl/tape_burst_reader.sv | 137 +++++++++++++
 tb/tb_tape_burst_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tape_reader_pkg.sv
// Shared types and helpers for the burst-mode tape reader.
package tape_reader_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        FLUSH
    } state_t;

    // DDR holds the tape image little-endian; playback wants the bytes reversed.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/tape_sync_fifo.sv
// Single-clock show-ahead FIFO with registered head word, sync clear and occupancy.
module tape_sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    remain;
    logic             pop;

    // A word written this edge only reaches the head register one edge later.
    assign pop        = rd_en && !empty;
    assign rd_ptr_nxt = rd_ptr + AW'(pop);
    assign remain     = count - CW'(pop);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr_nxt;
            count  <= count + CW'(wr_en) - CW'(pop);
            empty  <= (remain == '0);
            if (remain != '0)
                rd_data <= mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear && wr_en)
            assert (count != CW'(DEPTH));
    end

endmodule

// File: rtl/tape_burst_reader.sv
// Burst prefetcher streaming a tape image from DDR into a show-ahead FIFO.
// Define TAPE_READER_BYTE_SWAP_EN to byte-reverse each beat before buffering.
module tape_burst_reader
    import tape_reader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1F500000,
    parameter int          BURST_WORDS = 16,
    parameter int          FIFO_DEPTH  = 64,
    localparam int         CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    output logic [31:0]   mst_addr,
    output logic [11:0]   mst_length,
    output logic          mst_rd_req,
    output logic          mst_type,
    output logic          mst_rd_dst_rdy_n,
    input  logic          cmd_ack,
    input  logic [31:0]   mst_rd_d,
    input  logic          mst_rd_src_rdy_n,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic          empty,
    output logic [CW-1:0] count_in_buf,
    output logic          data_valid
);

    localparam int          BW          = $clog2(BURST_WORDS + 1);
    localparam logic [31:0] BURST_BYTES = 32'(BURST_WORDS * WORD_BYTES);

    state_t        state, state_nxt;
    logic [31:0]   cur_addr, cur_addr_nxt;
    logic [BW-1:0] beats, beats_nxt;
    logic [CW-1:0] free;
    logic [31:0]   wr_data;
    logic          beat, last, wr_en, clear;

    assign beat = !mst_rd_src_rdy_n && (state == RECV || state == FLUSH);
    assign last = beat && (beats == BW'(1));
    assign free = CW'(FIFO_DEPTH) - count_in_buf - CW'(beats);

`ifdef TAPE_READER_BYTE_SWAP_EN
    assign wr_data = byte_swap(mst_rd_d);
`else
    assign wr_data = mst_rd_d;
`endif

    always_comb begin
        state_nxt    = state;
        cur_addr_nxt = cur_addr;
        beats_nxt    = beats;
        wr_en        = 1'b0;
        clear        = 1'b0;
        if (beat)
            beats_nxt = beats - BW'(1);
        case (state)
            IDLE: begin
                if (restart) begin
                    clear        = 1'b1;
                    cur_addr_nxt = BASE_ADDR;
                end else if (free >= CW'(BURST_WORDS)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (restart) begin
                    clear        = 1'b1;
                    cur_addr_nxt = BASE_ADDR;
                    state_nxt    = IDLE;
                end else if (cmd_ack) begin
                    beats_nxt = BW'(BURST_WORDS);
                    state_nxt = RECV;
                end
            end
            RECV: begin
                wr_en = beat && !restart;
                if (restart) begin
                    // Beats still owed by the bridge are swallowed in FLUSH.
                    clear        = 1'b1;
                    cur_addr_nxt = BASE_ADDR;
                    state_nxt    = last ? IDLE : FLUSH;
                end else if (last) begin
                    cur_addr_nxt = cur_addr + BURST_BYTES;
                    state_nxt    = IDLE;
                end
            end
            FLUSH: begin
                if (restart) begin
                    clear        = 1'b1;
                    cur_addr_nxt = BASE_ADDR;
                end
                if (last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cur_addr         <= BASE_ADDR;
            beats            <= '0;
            mst_rd_req       <= 1'b0;
            mst_type         <= 1'b0;
            mst_rd_dst_rdy_n <= 1'b1;
        end else begin
            state            <= state_nxt;
            cur_addr         <= cur_addr_nxt;
            beats            <= beats_nxt;
            mst_rd_req       <= (state_nxt == REQ);
            mst_type         <= (state_nxt == REQ);
            mst_rd_dst_rdy_n <= !(state_nxt == RECV || state_nxt == FLUSH);
        end
    end

    assign mst_addr   = cur_addr;
    assign mst_length = 12'(BURST_WORDS * WORD_BYTES);
    assign data_valid = !empty;

    tape_sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .empty  (empty),
        .count  (count_in_buf)
    );

endmodule

// File: tb/tb_tape_burst_reader.sv
// Directed bench for tape_burst_reader with BURST_WORDS=4, FIFO_DEPTH=8.
module tb_tape_burst_reader;

    localparam logic [31:0] BASE = 32'h1F500000;

    logic        clk = 1'b0;
    logic        reset, restart, cmd_ack, mst_rd_src_rdy_n, rd_en;
    logic [31:0] mst_rd_d;
    logic [31:0] mst_addr, rd_data;
    logic [11:0] mst_length;
    logic        mst_rd_req, mst_type, mst_rd_dst_rdy_n, empty, data_valid;
    logic [3:0]  count_in_buf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tape_burst_reader #(
        .BASE_ADDR  (BASE),
        .BURST_WORDS(4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .restart         (restart),
        .mst_addr        (mst_addr),
        .mst_length      (mst_length),
        .mst_rd_req      (mst_rd_req),
        .mst_type        (mst_type),
        .mst_rd_dst_rdy_n(mst_rd_dst_rdy_n),
        .cmd_ack         (cmd_ack),
        .mst_rd_d        (mst_rd_d),
        .mst_rd_src_rdy_n(mst_rd_src_rdy_n),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .empty           (empty),
        .count_in_buf    (count_in_buf),
        .data_valid      (data_valid)
    );

    function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef TAPE_READER_BYTE_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        for (int i = 0; i < 20 && mst_rd_req !== 1'b1; i++)
            @(negedge clk);
        check({tag, "_req"}, 32'(mst_rd_req), 32'd1);
        check({tag, "_type"}, 32'(mst_type), 32'd1);
        check({tag, "_addr"}, mst_addr, addr);
        check({tag, "_len"}, 32'(mst_length), 32'd16);
    endtask

    task automatic ack(input string tag);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check({tag, "_req_drop"}, 32'(mst_rd_req), 32'd0);
        check({tag, "_dst_rdy"}, 32'(mst_rd_dst_rdy_n), 32'd0);
    endtask

    task automatic send(input logic [31:0] w);
        mst_rd_src_rdy_n = 1'b0;
        mst_rd_d         = w;
        @(negedge clk);
        mst_rd_src_rdy_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic        saw;
        reset = 1'b1; restart = 1'b0; cmd_ack = 1'b0;
        mst_rd_d = '0; mst_rd_src_rdy_n = 1'b1; rd_en = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req", 32'(mst_rd_req), 32'd0);
        check("rst_type", 32'(mst_type), 32'd0);
        check("rst_dst", 32'(mst_rd_dst_rdy_n), 32'd1);
        check("rst_addr", mst_addr, BASE);
        check("rst_len", 32'(mst_length), 32'd16);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_count", 32'(count_in_buf), 32'd0);
        check("rst_rdata", rd_data, 32'd0);
        reset = 1'b0;

        // cold start: first burst
        wait_req("b1", BASE);
        ack("b1");
        send(32'h11223344);
        check("lat_count", 32'(count_in_buf), 32'd1);
        check("lat_empty", 32'(empty), 32'd1);
        send(32'h55667788);
        check("lat_valid", 32'(empty), 32'd0);
        check("lat_rdata", rd_data, sw(32'h11223344));
        send(32'h99AABBCC);
        send(32'hDDEEFF00);

        // second burst with a 5-cycle source stall
        wait_req("b2", BASE + 32'h10);
        ack("b2");
        send(32'h01020304);
        send(32'h05060708);
        repeat (5) @(negedge clk);
        check("stall_count", 32'(count_in_buf), 32'd6);
        check("stall_dst", 32'(mst_rd_dst_rdy_n), 32'd0);
        send(32'h090A0B0C);
        send(32'h0D0E0F10);
        check("full_count", 32'(count_in_buf), 32'd8);

        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw |= mst_rd_req;
        end
        check("no_third_req", 32'(saw), 32'd0);
        check("full_count2", 32'(count_in_buf), 32'd8);
        check("full_rdata", rd_data, sw(32'h11223344));

        // single pop from full
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("pop1_count", 32'(count_in_buf), 32'd7);
        check("pop1_rdata", rd_data, sw(32'h55667788));
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw |= mst_rd_req;
        end
        check("pop1_no_req", 32'(saw), 32'd0);
        check("pop1_count2", 32'(count_in_buf), 32'd7);

        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        check("pop4_count", 32'(count_in_buf), 32'd4);
        check("pop4_rdata", rd_data, sw(32'h01020304));

        // third burst; pop while request is pending, then pop alongside a write
        wait_req("b3", BASE + 32'h20);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("reqpop_count", 32'(count_in_buf), 32'd3);
        check("reqpop_rdata", rd_data, sw(32'h05060708));
        check("reqpop_req_held", 32'(mst_rd_req), 32'd1);
        ack("b3");
        rd_en = 1'b1;
        send(32'hCAFE0001);
        rd_en = 1'b0;
        check("wrpop_count", 32'(count_in_buf), 32'd3);
        check("wrpop_rdata", rd_data, sw(32'h090A0B0C));
        send(32'hCAFE0002);
        send(32'hCAFE0003);
        send(32'hCAFE0004);
        @(negedge clk);
        check("b3_count", 32'(count_in_buf), 32'd6);

        exp_q = '{32'h090A0B0C, 32'h0D0E0F10, 32'hCAFE0001,
                  32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
        foreach (exp_q[i]) begin
            check($sformatf("drain%0d_rdata", i), rd_data, sw(exp_q[i]));
            check($sformatf("drain%0d_empty", i), 32'(empty), 32'd0);
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count_in_buf), 32'd0);

        // restart withdraws an unacked request
        wait_req("b4", BASE + 32'h30);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("wd_req", 32'(mst_rd_req), 32'd0);

        // restart on the second beat of a burst
        wait_req("b5", BASE);
        ack("b5");
        send(32'hAAAA0001);
        restart = 1'b1;
        send(32'hAAAA0002);
        restart = 1'b0;
        check("fl_empty0", 32'(empty), 32'd1);
        check("fl_count0", 32'(count_in_buf), 32'd0);
        check("fl_dst", 32'(mst_rd_dst_rdy_n), 32'd0);
        send(32'hAAAA0003);
        check("fl_empty1", 32'(empty), 32'd1);
        check("fl_req", 32'(mst_rd_req), 32'd0);
        send(32'hAAAA0004);
        check("fl_empty2", 32'(empty), 32'd1);
        check("fl_count2", 32'(count_in_buf), 32'd0);
        wait_req("b6", BASE);
        check("end_valid", 32'(data_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
